// File: rtl/adder_4bit.sv
// Registered WIDTH-bit ripple-carry adder with carry-in, carry-out,
// signed-overflow and zero flags. One-cycle latency, one op per cycle.
module adder_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             out_valid
);

  // Carry chain: carry[0] is the carry-in, carry[WIDTH] the MSB carry-out.
  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;
  logic             zero_c;

  assign carry_c[0] = Cin;

  // One full-adder cell per bit, rippling the carry upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa_cell
    assign sum_c[i]     = A[i] ^ B[i] ^ carry_c[i];
    assign carry_c[i+1] = (A[i] & B[i]) | (A[i] & carry_c[i]) | (B[i] & carry_c[i]);
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  // For WIDTH = 1 the carry into the MSB is Cin itself.
  assign ovf_c  = carry_c[WIDTH] ^ carry_c[WIDTH-1];
  assign zero_c = (sum_c == '0);

  // Output registers: capture on valid, hold otherwise; reset shows a zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_c;
        Cout <= carry_c[WIDTH];
        Ovf  <= ovf_c;
        Zero <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
// Directed self-checking bench for the registered 4-bit adder.
module tb_adder_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       Ovf;
  logic       Zero;
  logic       out_valid;

  int n_vec  = 0;
  int n_fail = 0;

  adder_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .Zero      (Zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output bundle: {Sum, Cout, Ovf, Zero, out_valid}.
  function automatic logic [7:0] obs();
    return {Sum, Cout, Ovf, Zero, out_valid};
  endfunction

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0; in_valid = 1'b1; A = 4'b0000; B = 4'b0000; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp = {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want %b", obs(), exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp = {4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_add();
    logic [7:0] exp;
    // 1011 + 0100 + 0 = 1111
    drive(1'b1, 4'b1011, 4'b0100, 1'b0);
    @(posedge clk); #1;
    exp = {4'b1111, 1'b0, 1'b0, 1'b0, 1'b1};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL add_b_4: got %b want %b", obs(), exp);
    end
    // 7 + (-3) + 1 = 5, unsigned carry out
    drive(1'b1, 4'b0111, 4'b1101, 1'b1);
    @(posedge clk); #1;
    exp = {4'b0101, 1'b1, 1'b0, 1'b0, 1'b1};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL add_7_m3_c: got %b want %b", obs(), exp);
    end
    // 7 + 1: positive signed overflow
    drive(1'b1, 4'b0111, 4'b0001, 1'b0);
    @(posedge clk); #1;
    exp = {4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL ovf_pos: got %b want %b", obs(), exp);
    end
    // -8 + -8: negative overflow, wraps to zero with carry
    drive(1'b1, 4'b1000, 4'b1000, 1'b0);
    @(posedge clk); #1;
    exp = {4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL ovf_neg: got %b want %b", obs(), exp);
    end
    // all-zeros boundary
    drive(1'b1, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk); #1;
    exp = {4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL all_zero: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp;
    // all-ones boundary, then idle cycles with changing operands
    drive(1'b1, 4'b1111, 4'b1111, 1'b1);
    @(posedge clk); #1;
    exp = {4'b1111, 1'b1, 1'b0, 1'b0, 1'b1};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL all_ones: got %b want %b", obs(), exp);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0011, 4'b0011, 1'b0);
      @(posedge clk); #1;
      exp = {4'b1111, 1'b1, 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL hold_%0d: got %b want %b", i, obs(), exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] exp;
    drive(1'b1, 4'b0101, 4'b0010, 1'b0);
    @(posedge clk); #1;
    exp = {4'b0111, 1'b0, 1'b0, 1'b0, 1'b1};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL pre_reset: got %b want %b", obs(), exp);
    end
    // Assert reset between edges; outputs must clear before the next edge.
    #2 rst_n = 1'b0;
    #1;
    exp = {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", obs(), exp);
    end
    // Release with no valid input: in-flight data discarded, out_valid stays 0.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; A = 4'b1010; B = 4'b0101; Cin = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] full;
    logic [7:0] exp;
    logic [3:0] a, b;
    logic       c, ovf;
    for (int i = 0; i < 512; i++) begin
      a = 4'(i >> 5);
      b = 4'(i >> 1);
      c = 1'(i);
      drive(1'b1, a, b, c);
      @(posedge clk); #1;
      full = 5'(a) + 5'(b) + 5'(c);
      ovf  = (a[3] == b[3]) && (full[3] != a[3]);
      exp  = {full[3:0], full[4], ovf, (full[3:0] == 4'b0000), 1'b1};
      n_vec++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL sweep a=%b b=%b cin=%b: got %b want %b", a, b, c, obs(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_4bit.md
Name: adder_4bit

Overview:
- Registered WIDTH-bit ripple-carry adder with carry-in, carry-out and status flags; default WIDTH = 4.
- Built as a chain of full-adder cells; the combinational result is captured in output registers on the rising clock edge.
- Used as a datapath arithmetic primitive wherever a clocked add with carry chaining is needed.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies A, B and Cin for capture this cycle.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B, unsigned or two's complement.
- Cin  input  1  carry-in, added at bit 0.
- Sum  output  WIDTH  registered (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  registered carry out of the MSB (unsigned overflow).
- Ovf  output  1  registered signed overflow.
- Zero  output  1  registered flag, 1 when Sum == 0.
- out_valid  output  1  registered in_valid, 1 for the cycle the result is presented.

Behaviour:
- Reset: asserting rst_n low immediately clears Sum, Cout, Ovf and out_valid to 0 and sets Zero to 1, independent of clk. Release is synchronous to the next rising edge; the first capture happens on the first rising edge with rst_n high.
- Combinational core:
  - Full-adder cell i: s[i] = A[i] ^ B[i] ^ c[i]; c[i+1] = A[i]&B[i] | A[i]&c[i] | B[i]&c[i]; c[0] = Cin.
  - Cells are instantiated in a generate loop over WIDTH.
- Flags:
  - Cout = c[WIDTH].
  - Ovf = c[WIDTH] ^ c[WIDTH-1]; for WIDTH = 1, c[WIDTH-1] is Cin.
  - Zero = (s == 0), computed from the combinational sum before the register.
- Latency: exactly 1 clock. Operands present with in_valid = 1 before edge N appear on Sum, Cout, Ovf and Zero after edge N, and out_valid = 1 after edge N.
- in_valid = 0 at an edge:
  - Sum, Cout, Ovf and Zero hold their previous values.
  - out_valid becomes 0.
- Throughput: one operation per cycle; back-to-back in_valid = 1 updates the outputs every cycle. There is no backpressure.
- Width rules:
  - The full result is WIDTH+1 bits, {Cout, Sum}.
  - Wrap-around is modulo 2^WIDTH, with the carry reported in Cout.
- X/Z on operands while in_valid = 0 must not corrupt the held outputs.
- Reset asserted mid-stream: in-flight results are discarded and out_valid = 0 until a new valid capture.
- Boundary cases:
  - All-ones + all-ones + 1 gives Sum all-ones, Cout = 1.
  - All-zeros + all-zeros + 0 gives Sum 0, Zero = 1, Cout = 0.

Test Plan:
1. Hold rst_n = 0, drive A = 0, B = 0, Cin = 0, in_valid = 1 -> Sum = 0000, Cout = 0, Ovf = 0, Zero = 1, out_valid = 0. Release reset, one edge -> Sum = 0000, Zero = 1, out_valid = 1.
2. A = 1011, B = 0100, Cin = 0, in_valid = 1, one edge -> Sum = 1111, Cout = 0, Ovf = 0, Zero = 0, out_valid = 1.
3. A = 0111, B = 1101, Cin = 1 -> Sum = 0101, Cout = 1, Ovf = 0 (7 + (-3) + 1 = 5).
4. A = 0111, B = 0001, Cin = 0 -> Sum = 1000, Cout = 0, Ovf = 1. Then A = 1000, B = 1000, Cin = 0 -> Sum = 0000, Cout = 1, Ovf = 1, Zero = 1.
5. A = 1111, B = 1111, Cin = 1, then in_valid = 0 with A = 0011, B = 0011 for 3 cycles:
   - after the valid edge: Sum = 1111, Cout = 1, out_valid = 1;
   - during the in_valid = 0 cycles: outputs stay Sum = 1111, Cout = 1, with out_valid = 0.
6. Pulse rst_n low between clock edges while out_valid = 1 -> all outputs clear immediately (Zero = 1), without waiting for clk. Then exhaustively sweep all 512 combinations of A, B, Cin back-to-back -> each result matches A + B + Cin one cycle later.
